// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control sequencer for a small accumulator CPU.
//
// Walks FETCH -> DECODE -> {EXEC | OPND | WAIT_IO | HALT} and back to FETCH.
// All strobes are Moore-decoded from the state register and the opcode latched
// in DECODE, qualified only by gt / in_valid / out_ready.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   run                 start request, looked at only in IDLE
//   step                single-step request (only with SINGLE_STEP_EN)
//   mova..halt          one-hot decoder outputs, sampled in DECODE
//   gt                  ALU greater-than flag (jg)
//   in_valid, out_ready I/O port handshakes
//   dec_en, ir_ld, mem_rd, pc_inc, pc_ld, imm_ld, reg_we, alu_en, alu_sub,
//   in_ack, out_we      control strobes
//   halted              processor stopped
//   state               current state encoding
//   instr_cnt           decoded-instruction counter (wraps)
//
// Compile-time option: define SINGLE_STEP_EN to add the step input and return
// to IDLE after every completed instruction.
module cpu_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic             run,
  input  logic             mova,
  input  logic             movb,
  input  logic             movc,
  input  logic             movd,
  input  logic             add,
  input  logic             sub,
  input  logic             jmp,
  input  logic             jg,
  input  logic             in1,
  input  logic             out1,
  input  logic             movi,
  input  logic             halt,
  input  logic             gt,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             dec_en,
  output logic             ir_ld,
  output logic             mem_rd,
  output logic             pc_inc,
  output logic             pc_ld,
  output logic             imm_ld,
  output logic             reg_we,
  output logic             alu_en,
  output logic             alu_sub,
  output logic             in_ack,
  output logic             out_we,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_OPND    = 3'd4,
    S_WAIT_IO = 3'd5,
    S_HALT    = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    OP_NONE, OP_MOVA, OP_MOVB, OP_MOVC, OP_MOVD, OP_ADD, OP_SUB,
    OP_JMP, OP_JG, OP_IN1, OP_OUT1, OP_MOVI, OP_HALT
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d, op_dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             go_c;

  // Where a finished instruction goes, and what wakes IDLE.
`ifdef SINGLE_STEP_EN
  localparam state_e DONE_STATE = S_IDLE;
  assign go_c = run | step;
`else
  localparam state_e DONE_STATE = S_FETCH;
  assign go_c = run;
`endif

  // Priority resolution of the decoder lines (multi-hot tolerated).
  always_comb begin
    op_dec = OP_NONE;
    if      (halt) op_dec = OP_HALT;
    else if (jmp)  op_dec = OP_JMP;
    else if (jg)   op_dec = OP_JG;
    else if (movi) op_dec = OP_MOVI;
    else if (in1)  op_dec = OP_IN1;
    else if (out1) op_dec = OP_OUT1;
    else if (add)  op_dec = OP_ADD;
    else if (sub)  op_dec = OP_SUB;
    else if (mova) op_dec = OP_MOVA;
    else if (movb) op_dec = OP_MOVB;
    else if (movc) op_dec = OP_MOVC;
    else if (movd) op_dec = OP_MOVD;
  end

  // Next-state, opcode/counter update and strobe decode.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    dec_en  = 1'b0;
    ir_ld   = 1'b0;
    mem_rd  = 1'b0;
    pc_inc  = 1'b0;
    pc_ld   = 1'b0;
    imm_ld  = 1'b0;
    reg_we  = 1'b0;
    alu_en  = 1'b0;
    alu_sub = 1'b0;
    in_ack  = 1'b0;
    out_we  = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go_c) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_rd  = 1'b1;
        ir_ld   = 1'b1;
        pc_inc  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        dec_en = 1'b1;
        op_d   = op_dec;
        cnt_d  = cnt_q + CNT_W'(1);
        case (op_dec)
          OP_HALT:                 state_d = S_HALT;
          OP_JMP, OP_JG, OP_MOVI:  state_d = S_OPND;
          OP_IN1, OP_OUT1:         state_d = S_WAIT_IO;
          OP_NONE:                 state_d = S_FETCH;   // NOP
          default:                 state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_MOVA, OP_MOVB, OP_MOVC, OP_MOVD: reg_we = 1'b1;
          OP_ADD: begin
            alu_en = 1'b1;
            reg_we = 1'b1;
          end
          OP_SUB: begin
            alu_en  = 1'b1;
            reg_we  = 1'b1;
            alu_sub = 1'b1;
          end
          default: ;
        endcase
        state_d = DONE_STATE;
      end
      S_OPND: begin
        mem_rd = 1'b1;
        case (op_q)
          OP_MOVI: begin
            imm_ld = 1'b1;
            reg_we = 1'b1;
            pc_inc = 1'b1;
          end
          OP_JMP:  pc_ld = 1'b1;
          // Not taken: step the PC over the operand word.
          OP_JG: begin
            pc_ld  = gt;
            pc_inc = ~gt;
          end
          default: ;
        endcase
        state_d = DONE_STATE;
      end
      S_WAIT_IO: begin
        if (op_q == OP_IN1) begin
          if (in_valid) begin
            in_ack  = 1'b1;
            reg_we  = 1'b1;
            state_d = DONE_STATE;
          end
        end else if (op_q == OP_OUT1) begin
          if (out_ready) begin
            out_we  = 1'b1;
            state_d = DONE_STATE;
          end
        end else begin
          state_d = DONE_STATE;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, opcode and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: self-checking bench for cpu_sequencer (CNT_W=4).
// Directed scenarios plus a randomized instruction stream checked against a
// behavioural model of the instruction set. Define SINGLE_STEP_EN to also
// exercise the single-step build.
module tb_cpu_sequencer;

  localparam int unsigned CW = 4;
`ifdef SINGLE_STEP_EN
  localparam bit SS = 1'b1;
`else
  localparam bit SS = 1'b0;
`endif

  // Strobe bit positions in the packed observation vector.
  localparam logic [11:0] M_DEC  = 12'h800, M_IR  = 12'h400, M_MEM = 12'h200,
                          M_PCI  = 12'h100, M_PCLD = 12'h080, M_IMM = 12'h040,
                          M_WE   = 12'h020, M_ALU = 12'h010, M_SUB = 12'h008,
                          M_ACK  = 12'h004, M_OUT = 12'h002, M_HLT = 12'h001;
  localparam logic [11:0] M_FETCH = M_MEM | M_IR | M_PCI;

  // Decoder vector in priority order: bit 11 = halt ... bit 0 = movd.
  localparam logic [11:0] D_HALT = 12'h800, D_JG = 12'h200, D_MOVI = 12'h100,
                          D_IN1 = 12'h080, D_OUT1 = 12'h040, D_ADD = 12'h020,
                          D_MOVA = 12'h008;

  logic clk = 1'b0, rst = 1'b1, run = 1'b0, step = 1'b0;
  logic gt = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [11:0] dec = 12'h000;

  logic dec_en, ir_ld, mem_rd, pc_inc, pc_ld, imm_ld, reg_we, alu_en, alu_sub;
  logic in_ack, out_we, halted;
  logic [2:0] state;
  logic [CW-1:0] instr_cnt;
  logic [11:0] strb;

  int n_chk = 0, n_fail = 0, cnt_m = 0;
  logic [2:0] xs;
  logic [11:0] xb;

  assign strb = {dec_en, ir_ld, mem_rd, pc_inc, pc_ld, imm_ld, reg_we, alu_en,
                 alu_sub, in_ack, out_we, halted};

  always #5 clk = ~clk;

  cpu_sequencer #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .run(run),
    .mova(dec[3]), .movb(dec[2]), .movc(dec[1]), .movd(dec[0]),
    .add(dec[5]), .sub(dec[4]), .jmp(dec[10]), .jg(dec[9]),
    .in1(dec[7]), .out1(dec[6]), .movi(dec[8]), .halt(dec[11]),
    .gt(gt), .in_valid(in_valid), .out_ready(out_ready),
    .dec_en(dec_en), .ir_ld(ir_ld), .mem_rd(mem_rd), .pc_inc(pc_inc),
    .pc_ld(pc_ld), .imm_ld(imm_ld), .reg_we(reg_we), .alu_en(alu_en),
    .alu_sub(alu_sub), .in_ack(in_ack), .out_we(out_we), .halted(halted),
    .state(state), .instr_cnt(instr_cnt)
  );

  // ---------------- behavioural model ----------------
  // Highest-priority instruction present (-1 = NOP).
  function automatic int pick(input logic [11:0] d);
    for (int i = 11; i >= 0; i--) if (d[i]) return i;
    return -1;
  endfunction

  // State the instruction occupies after DECODE.
  function automatic logic [2:0] body_state(input int op);
    if (op == 11) return 3'd6;
    if (op >= 8)  return 3'd4;
    if (op >= 6)  return 3'd5;
    return 3'd3;
  endfunction

  // Strobes in that body cycle.
  function automatic logic [11:0] body_strb(input int op, input logic g,
                                            input logic iv, input logic ordy);
    case (op)
      11: return M_HLT;
      10: return M_MEM | M_PCLD;
      9:  return g ? (M_MEM | M_PCLD) : (M_MEM | M_PCI);
      8:  return M_MEM | M_IMM | M_WE | M_PCI;
      7:  return iv ? (M_ACK | M_WE) : 12'h000;
      6:  return ordy ? M_OUT : 12'h000;
      5:  return M_ALU | M_WE;
      4:  return M_ALU | M_WE | M_SUB;
      default: return M_WE;
    endcase
  endfunction

  function automatic int inc_cnt(input int c);
    return (c + 1) % (1 << CW);
  endfunction

  // Apply inputs 2 time units after a rising edge; outputs settle by +3.
  task automatic drive(input logic r, input logic rn, input logic st,
                       input logic [11:0] d, input logic g, input logic iv,
                       input logic ordy);
    @(posedge clk);
    #2;
    rst = r; run = rn; step = st; dec = d; gt = g; in_valid = iv; out_ready = ordy;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    cnt_m = 0;
  endtask

  // Reset, then IDLE with run=1; leaves the DUT showing FETCH.
  task automatic start();
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1, 1'b1, 1'b1);
    cnt_m = 0;
    n_chk++;
    if ({state, strb, instr_cnt} !== {3'd0, 12'h000, CW'(0)}) begin
      n_fail++;
      $display("FAIL reset: got st=%0d strb=%03h cnt=%0d want st=0 strb=000 cnt=0", state, strb, instr_cnt);
    end
  endtask

  task automatic test_basic_add();
    logic [2:0] es [5];
    logic [11:0] eb [5];
    int ec [5];
    logic [11:0] dd [5];
    es = '{3'd0, 3'd1, 3'd2, 3'd3, SS ? 3'd0 : 3'd1};
    eb = '{12'h000, M_FETCH, M_DEC, M_ALU | M_WE, SS ? 12'h000 : M_FETCH};
    ec = '{0, 0, 0, 1, 1};
    dd = '{12'h000, 12'h000, D_ADD, 12'h000, 12'h000};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, dd[i], 1'b0, 1'b0, 1'b0);
      n_chk++;
      if ({state, strb, instr_cnt} !== {es[i], eb[i], CW'(ec[i])}) begin
        n_fail++;
        $display("FAIL add_seq[%0d]: got st=%0d strb=%03h cnt=%0d want st=%0d strb=%03h cnt=%0d",
                 i, state, strb, instr_cnt, es[i], eb[i], ec[i]);
      end
    end
  endtask

  task automatic test_jg();
    for (int g = 0; g < 2; g++) begin
      start();
      drive(1'b0, 1'b0, 1'b0, D_JG, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 12'h000, 1'(g), 1'b0, 1'b0);
      xb = (g != 0) ? (M_MEM | M_PCLD) : (M_MEM | M_PCI);
      n_chk++;
      if ({state, strb, instr_cnt} !== {3'd4, xb, CW'(1)}) begin
        n_fail++;
        $display("FAIL jg_gt%0d: got st=%0d strb=%03h cnt=%0d want st=4 strb=%03h cnt=1",
                 g, state, strb, instr_cnt, xb);
      end
    end
  endtask

  task automatic test_in_wait();
    start();
    drive(1'b0, 1'b0, 1'b0, D_IN1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 12'hFFF, 1'b1, 1'b0, 1'b1);
      n_chk++;
      if ({state, strb, instr_cnt} !== {3'd5, 12'h000, CW'(1)}) begin
        n_fail++;
        $display("FAIL in_wait[%0d]: got st=%0d strb=%03h cnt=%0d want st=5 strb=000 cnt=1",
                 i, state, strb, instr_cnt);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
    n_chk++;
    if ({state, strb, instr_cnt} !== {3'd5, M_ACK | M_WE, CW'(1)}) begin
      n_fail++;
      $display("FAIL in_ack: got st=%0d strb=%03h cnt=%0d want st=5 strb=%03h cnt=1",
               state, strb, instr_cnt, M_ACK | M_WE);
    end
    drive(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
    xs = SS ? 3'd0 : 3'd1;
    xb = SS ? 12'h000 : M_FETCH;
    n_chk++;
    if ({state, strb, instr_cnt} !== {xs, xb, CW'(1)}) begin
      n_fail++;
      $display("FAIL in_done: got st=%0d strb=%03h cnt=%0d want st=%0d strb=%03h cnt=1",
               state, strb, instr_cnt, xs, xb);
    end
  endtask

  task automatic test_halt();
    start();
    drive(1'b0, 1'b0, 1'b0, 12'hFFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b1, 12'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      n_chk++;
      if ({state, strb, instr_cnt} !== {3'd6, M_HLT, CW'(1)}) begin
        n_fail++;
        $display("FAIL halt_hold[%0d]: got st=%0d strb=%03h cnt=%0d want st=6 strb=001 cnt=1",
                 i, state, strb, instr_cnt);
      end
    end
    drive(1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if ({state, strb, instr_cnt} !== {3'd0, 12'h000, CW'(0)}) begin
      n_fail++;
      $display("FAIL halt_reset: got st=%0d strb=%03h cnt=%0d want st=0 strb=000 cnt=0",
               state, strb, instr_cnt);
    end
  endtask

  task automatic test_cnt_wrap();
    start();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
      cnt_m = inc_cnt(cnt_m);
      drive(1'b0, 1'b0, 1'b0, 12'($urandom), 1'b0, 1'b0, 1'b0);
      n_chk++;
      if ({state, strb, instr_cnt} !== {3'd1, M_FETCH, CW'(cnt_m)}) begin
        n_fail++;
        $display("FAIL nop_cnt[%0d]: got st=%0d strb=%03h cnt=%0d want st=1 strb=%03h cnt=%0d",
                 i, state, strb, instr_cnt, M_FETCH, cnt_m);
      end
    end
  endtask

  task automatic test_rst_mid();
    // Reset while in OPND (movi) and while in WAIT_IO (out1).
    logic [11:0] ops [2];
    ops = '{D_MOVI, D_OUT1};
    for (int k = 0; k < 2; k++) begin
      start();
      drive(1'b0, 1'b0, 1'b0, ops[k], 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b1, 12'hFFF, 1'b1, 1'b1, 1'b1);
      n_chk++;
      if ({state, strb, instr_cnt} !== {3'd0, 12'h000, CW'(0)}) begin
        n_fail++;
        $display("FAIL rst_mid[%0d]: got st=%0d strb=%03h cnt=%0d want st=0 strb=000 cnt=0",
                 k, state, strb, instr_cnt);
      end
    end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    start();
    drive(1'b0, 1'b0, 1'b0, D_MOVA, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if ({state, strb} !== {3'd0, 12'h000}) begin
        n_fail++;
        $display("FAIL ss_idle[%0d]: got st=%0d strb=%03h want st=0 strb=000", i, state, strb);
      end
    end
    drive(1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if ({state, strb} !== {3'd1, M_FETCH}) begin
      n_fail++;
      $display("FAIL ss_step: got st=%0d strb=%03h want st=1 strb=%03h", state, strb, M_FETCH);
    end
  endtask
`endif

  // Random instruction stream against the model.
  task automatic test_random(input int n_instr);
    logic [11:0] d;
    logic g, iv, ordy;
    int op, w;
    start();
    for (int i = 0; i < n_instr; i++) begin
      n_chk++;
      if ({state, strb, instr_cnt} !== {3'd1, M_FETCH, CW'(cnt_m)}) begin
        n_fail++;
        $display("FAIL rnd_fetch[%0d]: got st=%0d strb=%03h cnt=%0d want st=1 strb=%03h cnt=%0d",
                 i, state, strb, instr_cnt, M_FETCH, cnt_m);
      end
      case ($urandom_range(0, 3))
        0:       d = 12'h000;
        3:       d = 12'($urandom) & 12'h7FF;
        default: d = 12'(1) << $urandom_range(0, 10);
      endcase
      op = pick(d);
      drive(1'b0, 1'($urandom), 1'b0, d, 1'($urandom), 1'($urandom), 1'($urandom));
      n_chk++;
      if ({state, strb, instr_cnt} !== {3'd2, M_DEC, CW'(cnt_m)}) begin
        n_fail++;
        $display("FAIL rnd_decode[%0d]: got st=%0d strb=%03h cnt=%0d want st=2 strb=%03h cnt=%0d",
                 i, state, strb, instr_cnt, M_DEC, cnt_m);
      end
      cnt_m = inc_cnt(cnt_m);
      if (op >= 0) begin
        // I/O instructions wait a random number of cycles first.
        w = (op == 6 || op == 7) ? $urandom_range(0, 3) : 0;
        for (int k = 0; k <= w; k++) begin
          g = 1'($urandom);
          iv = 1'($urandom);
          ordy = 1'($urandom);
          if (op == 7) iv = (k == w);
          if (op == 6) ordy = (k == w);
          drive(1'b0, 1'($urandom), 1'b0, 12'($urandom), g, iv, ordy);
          xs = body_state(op);
          xb = body_strb(op, g, iv, ordy);
          n_chk++;
          if ({state, strb, instr_cnt} !== {xs, xb, CW'(cnt_m)}) begin
            n_fail++;
            $display("FAIL rnd_body[%0d] op=%0d: got st=%0d strb=%03h cnt=%0d want st=%0d strb=%03h cnt=%0d",
                     i, op, state, strb, instr_cnt, xs, xb, cnt_m);
          end
        end
        if (SS) drive(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
      end
      drive(1'b0, 1'($urandom), 1'b0, 12'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_jg();
    test_in_wait();
    test_halt();
    test_cnt_wrap();
    test_rst_mid();
`ifdef SINGLE_STEP_EN
    test_single_step();
`endif
    test_random(300);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter CNT_W SHALL default to 16 and set the instruction-counter width.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 run  input  1  start request; sampled only in IDLE.
REQ-006 mova, movb, movc, movd, add, sub, jmp, jg, in1, out1, movi, halt  input  1 each  one-hot decoder outputs; valid while dec_en=1.
REQ-007 gt  input  1  greater-than flag from the ALU, used by jg.
REQ-008 in_valid  input  1  input port holds data; out_ready  input  1  output port can accept data.
REQ-009 dec_en  output  1  decoder enable.
REQ-010 ir_ld, mem_rd, pc_inc, pc_ld, imm_ld  outputs  1 each  fetch and program-counter strobes.
REQ-011 reg_we, alu_en, alu_sub  outputs  1 each  register-write and ALU controls.
REQ-012 in_ack, out_we  outputs  1 each  I/O handshake strobes.
REQ-013 halted  output  1  processor stopped.
REQ-014 state  output  3  current state encoding.
REQ-015 instr_cnt  output  CNT_W  number of decoded instructions.

Function
REQ-016 States and encodings SHALL be: IDLE=0, FETCH=1, DECODE=2, EXEC=3, OPND=4, WAIT_IO=5, HALT=6; encoding 7 SHALL go to IDLE on the next cycle.
REQ-017 Outputs SHALL be Moore-decoded from the state register, the latched opcode, and the gt/in_valid/out_ready inputs; all strobes are 0 unless listed for a state.
REQ-018 IDLE: when run=1, go to FETCH; otherwise stay in IDLE.
REQ-019 FETCH: assert mem_rd, ir_ld and pc_inc for one cycle, then go to DECODE.
REQ-020 DECODE: assert dec_en and latch the one-hot inputs into the internal opcode; instr_cnt increments and wraps from all-ones to 0.
REQ-021 DECODE next state: halt->HALT; movi/jmp/jg->OPND; in1/out1->WAIT_IO; mov*/add/sub->EXEC.
REQ-022 DECODE with more than one input high: priority halt>jmp>jg>movi>in1>out1>add>sub>mova>movb>movc>movd.
REQ-023 DECODE with no input high: return to FETCH as a one-cycle NOP; instr_cnt still increments.
REQ-024 EXEC (one cycle): mov* asserts reg_we; add asserts alu_en and reg_we; sub additionally asserts alu_sub; then the instruction is complete.
REQ-025 OPND (one cycle), mem_rd always asserted:
  - movi: imm_ld, reg_we and pc_inc.
  - jmp: pc_ld.
  - jg with gt=1: pc_ld.
  - jg with gt=0: pc_inc, which skips the operand.
  - The instruction is then complete.
REQ-026 WAIT_IO for in1: hold until in_valid=1; in that cycle assert in_ack and reg_we, then complete.
REQ-027 WAIT_IO for out1: hold until out_ready=1; in that cycle assert out_we, then complete.
REQ-028 WAIT_IO has no timeout.
REQ-029 On instruction completion, go to FETCH (but see REQ-036).
REQ-030 HALT: halted=1 and all other strobes 0; run is ignored; HALT is left only by reset.
REQ-031 Cycle counts: register and ALU instructions take 3 cycles; movi, jmp and jg take 3 cycles; I/O instructions take 3 cycles plus the wait.

Reset
REQ-032 rst=1 at any clock edge, including mid-instruction or mid-WAIT_IO, SHALL force state to IDLE, clear the opcode and instr_cnt, and drive all outputs to 0 from the next cycle.
REQ-033 rst SHALL take priority over run and over all handshake inputs.

Configuration
REQ-034 The macro SINGLE_STEP_EN SHALL select single-step operation at compile time.
REQ-035 With SINGLE_STEP_EN defined, input step (1 bit) SHALL exist.
REQ-036 With SINGLE_STEP_EN defined, instruction completion SHALL go to IDLE instead of FETCH, and IDLE SHALL go to FETCH on run=1 or step=1.
REQ-037 Without SINGLE_STEP_EN, the step port SHALL be absent and completion SHALL go directly to FETCH.

Verification
REQ-038 Basic sequence: rst, then run=1 with decoder add=1 -> state 0,1,2,3,1; alu_en=reg_we=1 in cycle 3; alu_sub=0; instr_cnt=1.
REQ-039 Conditional jump: jg with gt=0 -> OPND asserts pc_inc, pc_ld=0; repeat with gt=1 -> pc_ld=1, pc_inc=0.
REQ-040 Input wait: in1 with in_valid held low for 5 cycles -> state stays 5 with in_ack=0; in_valid=1 -> in_ack=reg_we=1 for one cycle, then FETCH.
REQ-041 Halt and reset: halt decoded -> halted=1 persists for 20 cycles despite run=1; rst -> state=0, halted=0, instr_cnt=0.
REQ-042 Counter wrap: CNT_W=4 with 16 NOP decodes -> instr_cnt wraps to 0; rst asserted during OPND -> all strobes 0 on the next cycle.
REQ-043 Single step: with SINGLE_STEP_EN defined, execute mova -> returns to IDLE; no FETCH occurs until step=1.
